// File: rtl/rf_arb_pkg.sv
// Shared definitions for the two-port register-file arbiter: FSM states and
// register-file geometry.
package rf_arb_pkg;

    localparam int RF_DW     = 32;
    localparam int RF_AW     = 4;
    localparam int RF_DEPTH  = 16;
    localparam int NUM_PORTS = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } rf_state_t;

endpackage

// File: rtl/rf_arbiter_if.sv
// One requester port of the register-file arbiter: request handshake,
// command fields and completion/read-data return.
interface rf_arbiter_if
    import rf_arb_pkg::*;
#(
    parameter int DW = RF_DW,
    parameter int AW = RF_AW
);
    logic          valid;
    logic          ready;
    logic          re;
    logic          we;
    logic [AW-1:0] raddr1;
    logic [AW-1:0] raddr2;
    logic [AW-1:0] waddr;
    logic [DW-1:0] wdata;
    logic          resp_valid;
    logic [DW-1:0] rdata1;
    logic [DW-1:0] rdata2;

    modport master (
        output valid, re, we, raddr1, raddr2, waddr, wdata,
        input  ready, resp_valid, rdata1, rdata2
    );

    modport slave (
        input  valid, re, we, raddr1, raddr2, waddr, wdata,
        output ready, resp_valid, rdata1, rdata2
    );
endinterface

// File: rtl/rr_arb2.sv
// Two-request round-robin arbiter; the pointer remembers the last granted port
// and only moves when a grant is actually issued.
module rr_arb2
    import rf_arb_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_PORTS-1:0] req,
    input  logic                 en,
    output logic [NUM_PORTS-1:0] gnt
);
    logic last;

    always_comb begin
        gnt = '0;
        if (en) begin
            case (req)
                2'b01:   gnt = 2'b01;
                2'b10:   gnt = 2'b10;
                2'b11:   gnt = last ? 2'b01 : 2'b10;
                default: gnt = 2'b00;
            endcase
        end
    end

    // Reset to "port 1 last" so port 0 wins the first conflict.
    always_ff @(posedge clk) begin
        if (rst)
            last <= 1'b1;
        else if (|gnt)
            last <= gnt[1];
    end
endmodule

// File: rtl/rf_arbiter.sv
// Two-port register-file access arbiter: each accepted request runs
// IDLE -> ISSUE -> RESP, driving one register-file read/write in ISSUE.
module rf_arbiter
    import rf_arb_pkg::*;
#(
    parameter int DW = RF_DW,
    parameter int AW = RF_AW
) (
    input  logic          clk,
    input  logic          rst,
    rf_arbiter_if.slave   req0,
    rf_arbiter_if.slave   req1,
    output logic          rf_en,
    output logic          rf_rst,
    output logic          rf_rd,
    output logic          rf_wr,
    output logic [AW-1:0] rf_sel_i1,
    output logic [AW-1:0] rf_sel_o1,
    output logic [AW-1:0] rf_sel_o2,
    output logic [DW-1:0] rf_ip1,
    input  logic [DW-1:0] rf_op1,
    input  logic [DW-1:0] rf_op2
);
    rf_state_t            state, state_nxt;
    logic [NUM_PORTS-1:0] req_vld;
    logic [NUM_PORTS-1:0] gnt;
    logic                 arb_en;
    logic                 resp0, resp1;

    logic                 cmd_port;
    logic                 cmd_re;
    logic                 cmd_we;
    logic [AW-1:0]        cmd_raddr1;
    logic [AW-1:0]        cmd_raddr2;
    logic [AW-1:0]        cmd_waddr;
    logic [DW-1:0]        cmd_wdata;

    assign req_vld = {req1.valid, req0.valid};
    assign arb_en  = (state == IDLE) && !rst;

    rr_arb2 u_arb (
        .clk (clk),
        .rst (rst),
        .req (req_vld),
        .en  (arb_en),
        .gnt (gnt)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cmd_port   <= 1'b0;
            cmd_re     <= 1'b0;
            cmd_we     <= 1'b0;
            cmd_raddr1 <= '0;
            cmd_raddr2 <= '0;
            cmd_waddr  <= '0;
            cmd_wdata  <= '0;
        end else begin
            state <= state_nxt;
            if (gnt[1]) begin
                cmd_port   <= 1'b1;
                cmd_re     <= req1.re;
                cmd_we     <= req1.we;
                cmd_raddr1 <= req1.raddr1;
                cmd_raddr2 <= req1.raddr2;
                cmd_waddr  <= req1.waddr;
                cmd_wdata  <= req1.wdata;
            end else if (gnt[0]) begin
                cmd_port   <= 1'b0;
                cmd_re     <= req0.re;
                cmd_we     <= req0.we;
                cmd_raddr1 <= req0.raddr1;
                cmd_raddr2 <= req0.raddr2;
                cmd_waddr  <= req0.waddr;
                cmd_wdata  <= req0.wdata;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        rf_en     = 1'b0;
        rf_rd     = 1'b0;
        rf_wr     = 1'b0;
        resp0     = 1'b0;
        resp1     = 1'b0;
        case (state)
            IDLE: begin
                if (|gnt)
                    state_nxt = ISSUE;
            end
            ISSUE: begin
                rf_en     = 1'b1;
                rf_rd     = cmd_re;
                rf_wr     = cmd_we;
                state_nxt = RESP;
            end
            RESP: begin
                resp0     = !cmd_port;
                resp1     = cmd_port;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        // Reset aborts any in-flight operation and clears the register file.
        if (rst) begin
            state_nxt = IDLE;
            rf_en     = 1'b1;
            rf_rd     = 1'b0;
            rf_wr     = 1'b0;
            resp0     = 1'b0;
            resp1     = 1'b0;
        end
    end

    assign rf_rst    = rst;
    assign rf_sel_o1 = cmd_raddr1;
    assign rf_sel_o2 = cmd_raddr2;
    assign rf_sel_i1 = cmd_waddr;
    assign rf_ip1    = cmd_wdata;

    assign req0.ready      = gnt[0];
    assign req1.ready      = gnt[1];
    assign req0.resp_valid = resp0;
    assign req1.resp_valid = resp1;
    assign req0.rdata1     = rf_op1;
    assign req0.rdata2     = rf_op2;
    assign req1.rdata1     = rf_op1;
    assign req1.rdata2     = rf_op2;
endmodule

// File: tb/tb_rf_arbiter.sv
// Scoreboard bench for rf_arbiter: directed requests push expected grants and
// responses; a negedge monitor pops and compares against what the DUT presents.
module tb_rf_arbiter;
    import rf_arb_pkg::*;

    localparam int DW = 32;
    localparam int AW = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    rf_arbiter_if #(.DW(DW), .AW(AW)) p0 ();
    rf_arbiter_if #(.DW(DW), .AW(AW)) p1 ();

    logic          rf_en, rf_rst, rf_rd, rf_wr;
    logic [AW-1:0] rf_sel_i1, rf_sel_o1, rf_sel_o2;
    logic [DW-1:0] rf_ip1;
    logic [DW-1:0] rf_op1 = '0;
    logic [DW-1:0] rf_op2 = '0;

    rf_arbiter #(.DW(DW), .AW(AW)) dut (
        .clk       (clk),
        .rst       (rst),
        .req0      (p0.slave),
        .req1      (p1.slave),
        .rf_en     (rf_en),
        .rf_rst    (rf_rst),
        .rf_rd     (rf_rd),
        .rf_wr     (rf_wr),
        .rf_sel_i1 (rf_sel_i1),
        .rf_sel_o1 (rf_sel_o1),
        .rf_sel_o2 (rf_sel_o2),
        .rf_ip1    (rf_ip1),
        .rf_op1    (rf_op1),
        .rf_op2    (rf_op2)
    );

    // Register-file model: read data is the pre-write contents.
    logic [DW-1:0] mem [RF_DEPTH];
    always @(posedge clk) begin
        if (rf_en) begin
            if (rf_rst) begin
                for (int i = 0; i < RF_DEPTH; i++) mem[i] <= '0;
            end else begin
                if (rf_rd) begin
                    rf_op1 <= mem[rf_sel_o1];
                    rf_op2 <= mem[rf_sel_o2];
                end
                if (rf_wr) mem[rf_sel_i1] <= rf_ip1;
            end
        end
    end

    typedef struct {
        int            port;
        logic          re;
        logic          we;
        logic [AW-1:0] wa;
        logic [DW-1:0] wd;
    } gexp_t;

    typedef struct {
        int            port;
        logic          chk;
        logic [DW-1:0] d1;
        logic [DW-1:0] d2;
    } rexp_t;

    gexp_t gq[$];
    rexp_t rq[$];
    int    due_q[$];

    int    checks   = 0;
    int    failures = 0;
    int    cyc      = 0;
    logic  done     = 1'b0;
    logic  iss_pend = 1'b0;
    gexp_t iss_e;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor / scoreboard
    always @(negedge clk) begin
        if (iss_pend) begin
            logic erd, ewr;
            erd = rst ? 1'b0 : iss_e.re;
            ewr = rst ? 1'b0 : iss_e.we;
            checks++;
            if (rf_en !== 1'b1 || rf_rd !== erd || rf_wr !== ewr) begin
                failures++;
                $display("FAIL issue_strobes: en=%b rd=%b wr=%b, required en=1 rd=%b wr=%b",
                         rf_en, rf_rd, rf_wr, erd, ewr);
            end
            if (ewr) begin
                checks++;
                if (rf_sel_i1 !== iss_e.wa || rf_ip1 !== iss_e.wd) begin
                    failures++;
                    $display("FAIL issue_wdata: sel_i1=%0d ip1=%h, required %0d %h",
                             rf_sel_i1, rf_ip1, iss_e.wa, iss_e.wd);
                end
            end
            iss_pend = 1'b0;
        end

        if (rst) begin
            checks++;
            if (rf_rst !== 1'b1 || rf_en !== 1'b1 || rf_rd !== 1'b0 || rf_wr !== 1'b0 ||
                p0.ready !== 1'b0 || p1.ready !== 1'b0 ||
                p0.resp_valid !== 1'b0 || p1.resp_valid !== 1'b0) begin
                failures++;
                $display("FAIL reset_outputs: rst=%b en=%b rd=%b wr=%b rdy=%b%b resp=%b%b, required 1 1 0 0 rdy=00 resp=00",
                         rf_rst, rf_en, rf_rd, rf_wr, p1.ready, p0.ready,
                         p1.resp_valid, p0.resp_valid);
            end
            due_q.delete();
        end else begin
            if (p0.ready || p1.ready) begin
                checks++;
                if (p0.ready && p1.ready) begin
                    failures++;
                    $display("FAIL double_grant: ready1=%b ready0=%b, required one-hot", p1.ready, p0.ready);
                end else if (gq.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_grant: port %0d granted, required no grant", p1.ready ? 1 : 0);
                end else begin
                    gexp_t e;
                    e = gq.pop_front();
                    if ((p1.ready ? 1 : 0) != e.port) begin
                        failures++;
                        $display("FAIL grant_port: got %0d, required %0d", p1.ready ? 1 : 0, e.port);
                    end
                    iss_e    = e;
                    iss_pend = 1'b1;
                    due_q.push_back(cyc + 2);
                end
            end

            if (p0.resp_valid || p1.resp_valid) begin
                checks++;
                if (p0.resp_valid && p1.resp_valid) begin
                    failures++;
                    $display("FAIL double_resp: resp1=%b resp0=%b, required one-hot", p1.resp_valid, p0.resp_valid);
                end else if (rq.size() == 0 || due_q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_resp: port %0d responded, required no response", p1.resp_valid ? 1 : 0);
                end else begin
                    rexp_t r;
                    int    due;
                    r   = rq.pop_front();
                    due = due_q.pop_front();
                    if ((p1.resp_valid ? 1 : 0) != r.port || cyc != due) begin
                        failures++;
                        $display("FAIL resp_port_timing: port %0d at cycle %0d, required port %0d at cycle %0d",
                                 p1.resp_valid ? 1 : 0, cyc, r.port, due);
                    end
                    if (r.chk) begin
                        logic [DW-1:0] a1, a2;
                        a1 = p1.resp_valid ? p1.rdata1 : p0.rdata1;
                        a2 = p1.resp_valid ? p1.rdata2 : p0.rdata2;
                        if (a1 !== r.d1 || a2 !== r.d2) begin
                            failures++;
                            $display("FAIL resp_data: rdata1=%h rdata2=%h, required %h %h", a1, a2, r.d1, r.d2);
                        end
                    end
                end
            end
        end

        if (done) begin
            checks++;
            if (gq.size() != 0 || rq.size() != 0) begin
                failures++;
                $display("FAIL leftover: grants=%0d resps=%0d outstanding, required 0 0", gq.size(), rq.size());
            end
            $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
            $finish;
        end

        if (cyc > 3000) begin
            $display("FAIL watchdog: cycle %0d reached, required finish before 3000", cyc);
            $fatal(1, "watchdog");
        end
    end

    task automatic set_port(input int port, input logic v, input logic re, input logic we,
                            input logic [AW-1:0] ra1, input logic [AW-1:0] ra2,
                            input logic [AW-1:0] wa, input logic [DW-1:0] wd);
        if (port == 0) begin
            p0.valid = v; p0.re = re; p0.we = we;
            p0.raddr1 = ra1; p0.raddr2 = ra2; p0.waddr = wa; p0.wdata = wd;
        end else begin
            p1.valid = v; p1.re = re; p1.we = we;
            p1.raddr1 = ra1; p1.raddr2 = ra2; p1.waddr = wa; p1.wdata = wd;
        end
    endtask

    task automatic wait_ready(input int port);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(port == 0 ? p0.ready : p1.ready) && n < 10);
        if (!(port == 0 ? p0.ready : p1.ready)) begin
            $display("FAIL ready_timeout: port %0d never ready, required ready within 10 cycles", port);
            $fatal(1, "ready timeout");
        end
    endtask

    // Full single-port transaction; starts and ends 1 time unit after a posedge in IDLE.
    task automatic send(input int port, input logic re, input logic we,
                        input logic [AW-1:0] ra1, input logic [AW-1:0] ra2,
                        input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                        input logic chk, input logic [DW-1:0] d1, input logic [DW-1:0] d2);
        gq.push_back('{port, re, we, wa, wd});
        rq.push_back('{port, chk, d1, d2});
        set_port(port, 1'b1, re, we, ra1, ra2, wa, wd);
        wait_ready(port);
        @(posedge clk); #1;
        set_port(port, 1'b0, 1'b0, 1'b0, '0, '0, '0, '0);
        @(posedge clk);
        @(posedge clk); #1;
    endtask

    // Holds both ports valid (fields preset by caller) until n grants have been seen.
    task automatic run_both(input int n);
        int g = 0;
        int t = 0;
        p0.valid = 1'b1;
        p1.valid = 1'b1;
        while (g < n && t < 40) begin
            @(negedge clk);
            t++;
            if (p0.ready || p1.ready) g++;
        end
        if (g < n) begin
            $display("FAIL both_timeout: %0d grants seen, required %0d", g, n);
            $fatal(1, "grant timeout");
        end
        @(posedge clk); #1;
        p0.valid = 1'b0;
        p1.valid = 1'b0;
        @(posedge clk);
        @(posedge clk); #1;
    endtask

    initial begin
        rst = 1'b1;
        set_port(0, 1'b1, 1'b0, 1'b1, '0, '0, 4'd1, 32'h5555_5555);
        set_port(1, 1'b0, 1'b0, 1'b0, '0, '0, '0, '0);
        repeat (3) @(posedge clk);
        #1;
        set_port(0, 1'b0, 1'b0, 1'b0, '0, '0, '0, '0);
        rst = 1'b0;

        // Write then read back through port 0
        send(0, 1'b0, 1'b1, 4'd0, 4'd0, 4'd3, 32'hDEAD_BEEF, 1'b0, '0, '0);
        send(0, 1'b1, 1'b0, 4'd3, 4'd0, 4'd0, '0, 1'b1, 32'hDEAD_BEEF, 32'h0);
        // No-op request still completes
        send(0, 1'b0, 1'b0, 4'd0, 4'd0, 4'd0, '0, 1'b0, '0, '0);

        // Read-during-write returns the old value
        send(1, 1'b0, 1'b1, 4'd0, 4'd0, 4'd5, 32'h11, 1'b0, '0, '0);
        send(1, 1'b1, 1'b1, 4'd5, 4'd3, 4'd5, 32'h22, 1'b1, 32'h11, 32'hDEAD_BEEF);
        send(1, 1'b1, 1'b0, 4'd5, 4'd0, 4'd0, '0, 1'b1, 32'h22, 32'h0);

        // Both ports held valid: last grant was port 1, so 0,1,0,1
        set_port(0, 1'b0, 1'b1, 1'b0, 4'd3, 4'd5, '0, '0);
        set_port(1, 1'b0, 1'b1, 1'b0, 4'd5, 4'd3, '0, '0);
        for (int i = 0; i < 4; i++) begin
            int p;
            p = i % 2;
            gq.push_back('{p, 1'b1, 1'b0, 4'd0, 32'h0});
            if (p == 0) rq.push_back('{0, 1'b1, 32'hDEAD_BEEF, 32'h22});
            else        rq.push_back('{1, 1'b1, 32'h22, 32'hDEAD_BEEF});
        end
        run_both(4);

        // Port 1 pulses valid only during ISSUE of a port-0 op: no grant, pointer stays at 0
        gq.push_back('{0, 1'b1, 1'b0, 4'd0, 32'h0});
        rq.push_back('{0, 1'b1, 32'h22, 32'hDEAD_BEEF});
        set_port(0, 1'b1, 1'b1, 1'b0, 4'd5, 4'd3, '0, '0);
        wait_ready(0);
        @(posedge clk); #1;
        p0.valid = 1'b0;
        set_port(1, 1'b1, 1'b0, 1'b0, '0, '0, '0, '0);
        @(posedge clk); #1;
        p1.valid = 1'b0;
        @(posedge clk); #1;
        // Last grant was port 0, so the next conflict goes to port 1 first
        set_port(0, 1'b0, 1'b1, 1'b0, 4'd5, 4'd0, '0, '0);
        set_port(1, 1'b0, 1'b1, 1'b0, 4'd3, 4'd0, '0, '0);
        gq.push_back('{1, 1'b1, 1'b0, 4'd0, 32'h0});
        rq.push_back('{1, 1'b1, 32'hDEAD_BEEF, 32'h0});
        gq.push_back('{0, 1'b1, 1'b0, 4'd0, 32'h0});
        rq.push_back('{0, 1'b1, 32'h22, 32'h0});
        run_both(2);

        // Reset during ISSUE of a write to reg 7 aborts it
        gq.push_back('{0, 1'b0, 1'b1, 4'd7, 32'h77});
        set_port(0, 1'b1, 1'b0, 1'b1, '0, '0, 4'd7, 32'h77);
        wait_ready(0);
        @(posedge clk); #1;
        set_port(0, 1'b0, 1'b0, 1'b0, '0, '0, '0, '0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        send(0, 1'b1, 1'b0, 4'd7, 4'd3, 4'd0, '0, 1'b1, 32'h0, 32'h0);

        repeat (3) @(posedge clk);
        #1;
        done = 1'b1;
    end
endmodule
